data_memory_controller: RTL

//   MEM-stage sequencer between the ALU result (byte address) and the asynchronous data Memory.

---
 rtl/data_memory_controller_pkg.sv | 31 +++
 rtl/dmem_strobe_timer.sv | 41 ++++
 rtl/data_memory_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/data_memory_controller_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory sequencer.
package data_memory_controller_pkg;

  // Sequencer states: one access walks IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
  typedef enum logic [1:0] {
    DMC_IDLE   = 2'd0,
    DMC_SETUP  = 2'd1,
    DMC_STROBE = 2'd2,
    DMC_HOLD   = 2'd3
  } dmc_state_e;

  // Latched operation of the access in flight.
  typedef enum logic {
    DMC_OP_READ  = 1'b0,
    DMC_OP_WRITE = 1'b1
  } dmc_op_e;

  // A request is refused when it asks for both operations, is not word
  // aligned, or points past the last word of the memory. addr_limit is the
  // first illegal byte address (4 * number of words), kept 33 bits wide so
  // a full 32-bit address space still compares correctly.
  function automatic logic dmc_reject(
    input logic        rd,
    input logic        wr,
    input logic [31:0] addr,
    input logic [32:0] addr_limit
  );
    return (rd & wr) | (addr[1:0] != 2'b00) | ({1'b0, addr} >= addr_limit);
  endfunction

endpackage

// File: rtl/dmem_strobe_timer.sv
// Down-counter that times how long the memory strobe stays high.
// load presets the count to WAIT_CYCLES-1; dec counts down and sticks at 0;
// zero flags the last strobe cycle.
module dmem_strobe_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int              CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins over decrement; never wrap below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/data_memory_controller.sv
// MEM-stage sequencer: turns one lw/sw into a setup / strobe / hold sequence
// on an asynchronous data memory and stalls the pipeline meanwhile.
// Memory-side pins are all registered so nothing from the pipeline reaches
// the memory combinationally.
module data_memory_controller
  import data_memory_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,    // strobe width in cycles, 1..15
  parameter int MEM_WORDS   = 4096  // words present in the memory
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] m_addr,
  output logic        m_ren,
  output logic        m_wen,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  dmc_state_e  state_q, state_d;
  dmc_op_e     op_q, op_d;
  // m_addr_q / m_din_q double as the latched request address and store data:
  // they are loaded on acceptance and held unchanged until the next one.
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_din_q, m_din_d;
  logic        m_ren_q, m_ren_d;
  logic        m_wen_q, m_wen_d;
  logic [31:0] rdata_q, rdata_d;

  logic request;
  logic reject;
  logic accept;
  logic timer_load;
  logic timer_dec;
  logic timer_zero;

  // Classify the incoming request; only meaningful while IDLE.
  always_comb begin
    request = req_valid & (mem_read | mem_write);
    reject  = request & dmc_reject(mem_read, mem_write, addr, ADDR_LIMIT);
    accept  = request & ~reject;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DMC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed one-cycle setup and hold around a timed strobe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMC_IDLE:   if (accept) state_d = DMC_SETUP;
      DMC_SETUP:  state_d = DMC_STROBE;
      DMC_STROBE: if (timer_zero) state_d = DMC_HOLD;
      DMC_HOLD:   state_d = DMC_IDLE;
      default:    state_d = DMC_IDLE;
    endcase
  end

  // FSM outputs toward the pipeline. stall and err are forced low while
  // reset is asserted so the pipeline sees a quiet controller at once.
  always_comb begin
    stall = 1'b0;
    err   = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      DMC_IDLE: begin
        stall = accept & ~reset;
        err   = reject & ~reset;
      end
      DMC_SETUP:  stall = 1'b1;
      DMC_STROBE: stall = 1'b1;
      DMC_HOLD:   done  = 1'b1;
      default:    stall = 1'b0;
    endcase
  end

  // Strobe timer is preset during SETUP and counts down through STROBE.
  assign timer_load = (state_q == DMC_SETUP);
  assign timer_dec  = (state_q == DMC_STROBE);

  dmem_strobe_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_strobe_timer (
    .clock(clock),
    .reset(reset),
    .load (timer_load),
    .dec  (timer_dec),
    .zero (timer_zero)
  );

  // Datapath next values: latch the request on acceptance, capture load data
  // on the last strobe cycle, and derive the strobes from the next state so
  // they rise exactly on STROBE entry and fall exactly on STROBE exit.
  always_comb begin
    op_d     = op_q;
    m_addr_d = m_addr_q;
    m_din_d  = m_din_q;
    rdata_d  = rdata_q;
    if ((state_q == DMC_IDLE) && accept) begin
      op_d     = mem_write ? DMC_OP_WRITE : DMC_OP_READ;
      m_addr_d = {2'b00, addr[31:2]};
      m_din_d  = wdata;
    end
    if ((state_q == DMC_STROBE) && timer_zero && (op_q == DMC_OP_READ)) begin
      rdata_d = m_dout;
    end
    m_ren_d = (state_d == DMC_STROBE) && (op_q == DMC_OP_READ);
    m_wen_d = (state_d == DMC_STROBE) && (op_q == DMC_OP_WRITE);
  end

  // Datapath registers; reset drops the strobes immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= DMC_OP_READ;
      m_addr_q <= '0;
      m_din_q  <= '0;
      m_ren_q  <= 1'b0;
      m_wen_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      op_q     <= op_d;
      m_addr_q <= m_addr_d;
      m_din_q  <= m_din_d;
      m_ren_q  <= m_ren_d;
      m_wen_q  <= m_wen_d;
      rdata_q  <= rdata_d;
    end
  end

  assign m_addr = m_addr_q;
  assign m_din  = m_din_q;
  assign m_ren  = m_ren_q;
  assign m_wen  = m_wen_q;
  assign rdata  = rdata_q;

endmodule
